uart_rx_fifo: RTL and testbench

Receive-side buffer directly downstream of the UART core's receiver.
- Captures each received byte with its error flag (parity or frame) when the core raises rx_ready.
- Stores entries in a DEPTH-deep first-word-fall-through (FWFT) FIFO.
- Presents them to the consumer on a valid/ready read port, with level, full, empty and sticky overflow status.
- Decouples the byte-rate UART from a slower or bursty consumer.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_fifo_mem.sv | 54 +++++
 rtl/uart_rx_fifo.sv | 178 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: the receive data width, the default depth of the
// receive FIFO, and the stored FIFO entry type (error flag + data byte).
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;

  typedef struct packed {
    logic                   err;
    logic [UART_DATA_W-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_mem
// Storage array for the receive FIFO. It has one synchronous write port and
// one asynchronous read port. The storage cells have no reset, so pointer
// state alone decides which entries are valid.
//
// Optional build macro: UART_RX_FIFO_IRQ_EN adds a second asynchronous read
// port, pk_addr/pk_entry. The interrupt logic uses it to look ahead at the
// next head entry.
//
// Ports:
//   clk       system clock
//   wr_en     write strobe
//   wr_addr   write address
//   wr_entry  entry to store
//   rd_addr   read address (FIFO head)
//   rd_entry  entry at rd_addr
//   pk_addr   look-ahead read address   (UART_RX_FIFO_IRQ_EN only)
//   pk_entry  entry at pk_addr          (UART_RX_FIFO_IRQ_EN only)
// ---------------------------------------------------------------------------
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  rx_entry_t         wr_entry,
  input  logic [ADDR_W-1:0] rd_addr,
  output rx_entry_t         rd_entry
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  input  logic [ADDR_W-1:0] pk_addr,
  output rx_entry_t         pk_entry
`endif
);

  rx_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_entry;
    end
  end

  assign rd_entry = mem[rd_addr];

`ifdef UART_RX_FIFO_IRQ_EN
  assign pk_entry = mem[pk_addr];
`endif

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer placed downstream of the UART receiver. It captures one
// {err, data} entry on each 0->1 transition of rx_ready and holds the entries
// in a DEPTH-deep first-word-fall-through FIFO. The consumer reads them
// through a valid/ready port. The block also reports level, full, empty and
// a sticky overflow flag.
//
// Optional build macro: UART_RX_FIFO_IRQ_EN adds the THRESH parameter and a
// registered irq output.
//
// Ports:
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   clr       synchronous flush; takes priority over write and pop
//   rx_data   received byte, sampled on the rising edge of rx_ready
//   rx_ready  byte-available flag from the receiver (level or pulse)
//   rx_err    parity/frame error for rx_data
//   rd_ready  consumer accepts the head entry
//   rd_valid  head entry available
//   rd_data   head data (zero when empty)
//   rd_err    head error flag (zero when empty)
//   level     entry count, 0..DEPTH
//   full      level == DEPTH
//   empty     level == 0
//   ovf_clr   clears overflow
//   overflow  sticky: a byte was dropped because the FIFO was full
//   irq       level >= THRESH, overflow, or error at head (macro only)
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_RX_FIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W,
`ifdef UART_RX_FIFO_IRQ_EN
  parameter int THRESH = DEPTH / 2,
`endif
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  input  logic              rx_err,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty,
  input  logic              ovf_clr,
  output logic              overflow
`ifdef UART_RX_FIFO_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int               ADDR_W  = LVL_W - 1;
  localparam logic [LVL_W-1:0] PTR_ONE = LVL_W'(1);

  logic [LVL_W-1:0] wptr, rptr;
  logic [LVL_W-1:0] wptr_next, rptr_next;
  logic             rx_ready_q;
  logic             rx_rise, pop, wr_en, ovf_evt;
  logic             overflow_next;
  rx_entry_t        wr_entry, head;

  // Pointers carry one extra wrap bit. Equal pointers mean empty. Equal
  // addresses with different wrap bits mean full.
  assign level    = wptr - rptr;
  assign empty    = (wptr == rptr);
  assign full     = (wptr[LVL_W-1] != rptr[LVL_W-1]) &&
                    (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign rd_valid = ~empty;

  assign rx_rise  = rx_ready & ~rx_ready_q;
  assign pop      = rd_valid & rd_ready;
  // When the FIFO is full, a pop in the same cycle frees the slot that this
  // write fills.
  assign wr_en    = rx_rise & (~full | pop) & ~clr;
  assign ovf_evt  = rx_rise & full & ~pop;

  always_comb begin
    wr_entry      = '0;
    wr_entry.err  = rx_err;
    wr_entry.data = rx_data;
  end

  always_comb begin
    wptr_next     = wptr;
    rptr_next     = rptr;
    overflow_next = overflow;
    if (clr) begin
      wptr_next     = '0;
      rptr_next     = '0;
      overflow_next = 1'b0;
    end else begin
      if (wr_en) wptr_next = wptr + PTR_ONE;
      if (pop)   rptr_next = rptr + PTR_ONE;
      // A new overflow wins over a simultaneous ovf_clr.
      if (ovf_evt)      overflow_next = 1'b1;
      else if (ovf_clr) overflow_next = 1'b0;
    end
  end

  // The edge register keeps tracking rx_ready through clr. A level held
  // across a flush is therefore not written a second time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      overflow   <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      wptr       <= wptr_next;
      rptr       <= rptr_next;
      overflow   <= overflow_next;
      rx_ready_q <= rx_ready;
    end
  end

`ifdef UART_RX_FIFO_IRQ_EN
  rx_entry_t        pk_entry;
  logic [LVL_W-1:0] level_next;
  logic             head_err_next;
  logic             irq_next;

  uart_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wptr[ADDR_W-1:0]),
    .wr_entry(wr_entry),
    .rd_addr (rptr[ADDR_W-1:0]),
    .rd_entry(head),
    .pk_addr (rptr_next[ADDR_W-1:0]),
    .pk_entry(pk_entry)
  );

  // If this cycle's write lands on the next head slot (the FIFO drains to
  // empty and refills), the memory still holds the old value. In that case
  // take the error flag straight from the input.
  always_comb begin
    level_next    = wptr_next - rptr_next;
    head_err_next = (wr_en && (rptr_next == wptr)) ? rx_err : pk_entry.err;
    irq_next      = (level_next >= LVL_W'(THRESH)) | overflow_next |
                    (head_err_next & (level_next != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= irq_next;
  end
`else
  uart_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wptr[ADDR_W-1:0]),
    .wr_entry(wr_entry),
    .rd_addr (rptr[ADDR_W-1:0]),
    .rd_entry(head)
  );
`endif

  // Mask the head while the FIFO is empty so that the outputs read zero
  // instead of stale storage.
  assign rd_data = empty ? '0   : head.data;
  assign rd_err  = empty ? 1'b0 : head.err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 8;
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int THRESH = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clr = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic              rx_ready = 1'b0;
  logic              rx_err = 1'b0;
  logic              rd_ready = 1'b0;
  logic              ovf_clr = 1'b0;
  logic              rd_valid, rd_err, full, empty, overflow;
  logic [DATA_W-1:0] rd_data;
  logic [LVL_W-1:0]  level;
`ifdef UART_RX_FIFO_IRQ_EN
  logic              irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of {err, data}, the overflow flag, and the
  // previous rx_ready value used to detect 0->1 transitions.
  logic [DATA_W:0] mq[$];
  bit              m_ovf  = 1'b0;
  bit              m_prev = 1'b0;

  uart_rx_fifo #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W)
`ifdef UART_RX_FIFO_IRQ_EN
    , .THRESH(THRESH)
`endif
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .rx_data (rx_data),
    .rx_ready(rx_ready),
    .rx_err  (rx_err),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .rd_err  (rd_err),
    .level   (level),
    .full    (full),
    .empty   (empty),
    .ovf_clr (ovf_clr),
    .overflow(overflow)
`ifdef UART_RX_FIFO_IRQ_EN
    , .irq   (irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Apply the spec's rules to the model for the inputs present now, then
  // advance the DUT through one clock edge.
  task automatic step();
    bit rise, pop, ovf_evt;
    rise = rx_ready && !m_prev;
    pop  = rd_ready && (mq.size() > 0);
    if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      ovf_evt = rise && (mq.size() == DEPTH) && !pop;
      if (pop) void'(mq.pop_front());
      if (rise && !ovf_evt) mq.push_back({rx_err, rx_data});
      if (ovf_evt)      m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
    end
    m_prev = rx_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rx_ready = 1'b0; rd_ready = 1'b0; clr = 1'b0; ovf_clr = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mq.delete(); m_ovf = 1'b0; m_prev = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic e, input int hold);
    rx_data = d; rx_err = e; rx_ready = 1'b1;
    repeat (hold) step();
    rx_ready = 1'b0;
    step();
  endtask

  function automatic bit model_irq();
    return (mq.size() >= THRESH) || m_ovf || ((mq.size() > 0) && mq[0][DATA_W]);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_valid !== 1'b0 || level !== '0 || full !== 1'b0 || empty !== 1'b1 ||
        overflow !== 1'b0 || rd_data !== '0 || rd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b level=%0d full=%b empty=%b ovf=%b data=%h err=%b, required 0 0 0 1 0 00 0",
               rd_valid, level, full, empty, overflow, rd_data, rd_err);
    end
`ifdef UART_RX_FIFO_IRQ_EN
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b required 0", irq); end
`endif
    apply_reset();
  endtask

  task automatic test_level_pulses();
    logic [7:0] exp_d[3];
    logic       exp_e[3];
    exp_d[0] = 8'h5A; exp_d[1] = 8'hA5; exp_d[2] = 8'h00;
    exp_e[0] = 1'b0;  exp_e[1] = 1'b0;  exp_e[2] = 1'b1;
    apply_reset();
    for (int i = 0; i < 3; i++) push_byte(exp_d[i], exp_e[i], 20);
    n_checks++;
    if (level !== LVL_W'(3)) begin n_fail++; $display("FAIL pulses_level: got %0d required 3", level); end
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rd_valid !== 1'b1 || rd_data !== exp_d[i] || rd_err !== exp_e[i]) begin
        n_fail++;
        $display("FAIL pulses_read%0d: got v=%b %h/%b required 1 %h/%b", i, rd_valid, rd_data, rd_err, exp_d[i], exp_e[i]);
      end
      step();
    end
    rd_ready = 1'b0;
    n_checks++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL pulses_empty: got %b required 1", empty); end
  endtask

  task automatic test_held_level();
    apply_reset();
    push_byte(8'h33, 1'b0, 100);
    n_checks++;
    if (level !== LVL_W'(1) || rd_data !== 8'h33) begin
      n_fail++;
      $display("FAIL held_level: got level=%0d data=%h required 1 33", level, rd_data);
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0, 1);
    n_checks++;
    if (full !== 1'b1 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_full16: got full=%b ovf=%b required 1 0", full, overflow);
    end
    push_byte(8'h10, 1'b0, 1);
    n_checks++;
    if (overflow !== 1'b1 || level !== LVL_W'(16)) begin
      n_fail++; $display("FAIL ovf_set: got ovf=%b level=%0d required 1 16", overflow, level);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (rd_data !== 8'(i) || rd_valid !== 1'b1) begin
        n_fail++; $display("FAIL ovf_read%0d: got v=%b %h required 1 %h", i, rd_valid, rd_data, 8'(i));
      end
      step();
    end
    rd_ready = 1'b0;
    n_checks++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL ovf_drained: got empty=%b ovf=%b required 1 1", empty, overflow);
    end
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b required 0", overflow); end
  endtask

  task automatic test_full_simul();
    logic [8:0] exp;
    apply_reset();
    for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i), 1'b0, 1);
    rx_data = 8'hEE; rx_err = 1'b0; rx_ready = 1'b1; rd_ready = 1'b1;
    step();
    rx_ready = 1'b0; rd_ready = 1'b0;
    step();
    n_checks++;
    if (level !== LVL_W'(16) || overflow !== 1'b0 || full !== 1'b1) begin
      n_fail++; $display("FAIL simul_full: got level=%0d ovf=%b full=%b required 16 0 1", level, overflow, full);
    end
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = (i == 15) ? 9'h0EE : {1'b0, 8'h81 + 8'(i)};
      n_checks++;
      if ({rd_err, rd_data} !== exp) begin
        n_fail++; $display("FAIL simul_read%0d: got %h required %h", i, {rd_err, rd_data}, exp);
      end
      step();
    end
    rd_ready = 1'b0;
  endtask

  task automatic test_clr_and_async_reset();
    apply_reset();
    for (int i = 0; i < 5; i++) push_byte(8'h40 + 8'(i), 1'b1, 1);
    rx_data = 8'h77; rx_err = 1'b0; rx_ready = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (5) step();
    n_checks++;
    if (level !== '0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL clr_flush: got level=%0d empty=%b valid=%b required 0 1 0", level, empty, rd_valid);
    end
    rx_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) push_byte(8'hC0 + 8'(i), 1'b0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (rd_valid !== 1'b0 || level !== '0 || full !== 1'b0 || empty !== 1'b1 ||
        overflow !== 1'b0 || rd_data !== '0 || rd_err !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b level=%0d empty=%b data=%h required 0 0 1 00", rd_valid, level, empty, rd_data);
    end
    rst_n = 1'b1;
    mq.delete(); m_ovf = 1'b0; m_prev = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [8:0] exp_head;
    apply_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 2) == 0) rx_ready = ~rx_ready;
      rx_data  = 8'($urandom);
      rx_err   = ($urandom_range(0, 5) == 0);
      rd_ready = (cyc % 300 < 150) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 9) < 7);
      ovf_clr  = ($urandom_range(0, 15) == 0);
      clr      = ($urandom_range(0, 99) == 0);
      step();
      exp_head = (mq.size() > 0) ? mq[0] : '0;
      n_checks++;
      if (level !== LVL_W'(mq.size()) || full !== (mq.size() == DEPTH) ||
          empty !== (mq.size() == 0) || rd_valid !== (mq.size() > 0) ||
          overflow !== m_ovf || {rd_err, rd_data} !== exp_head) begin
        n_fail++;
        $display("FAIL random_c%0d: got lvl=%0d f=%b e=%b v=%b ovf=%b head=%h required lvl=%0d ovf=%b head=%h",
                 cyc, level, full, empty, rd_valid, overflow, {rd_err, rd_data}, mq.size(), m_ovf, exp_head);
      end
`ifdef UART_RX_FIFO_IRQ_EN
      n_checks++;
      if (irq !== model_irq()) begin
        n_fail++; $display("FAIL random_irq_c%0d: got %b required %b", cyc, irq, model_irq());
      end
`endif
    end
    rx_ready = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0; clr = 1'b0;
    step();
  endtask

`ifdef UART_RX_FIFO_IRQ_EN
  task automatic test_irq();
    apply_reset();
    for (int i = 0; i < 3; i++) push_byte(8'h10 + 8'(i), 1'b0, 1);
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_below: got %b required 0", irq); end
    rx_data = 8'h13; rx_err = 1'b0; rx_ready = 1'b1;
    step();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise: got %b required 1", irq); end
    rx_ready = 1'b0; rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_fall: got %b required 0", irq); end
  endtask
`endif

  initial begin
    test_reset();
    test_level_pulses();
    test_held_level();
    test_overflow();
    test_full_simul();
    test_clr_and_async_reset();
`ifdef UART_RX_FIFO_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
